// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write/read-back BIST sequencer and sole master of a single-port memory.
// Writes a selectable pattern to every word, reads each word back, and reports the outcome.
module mem_bist_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        pattern_sel,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              timeout,
   output logic              W_en,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] Data_in,
   input  logic [DATA_W-1:0] Data_out,
   input  logic              Valid_out
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ERR_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   ERR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WRITE     = 3'd1,
      S_READ_REQ  = 3'd2,
      S_READ_WAIT = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   // Address-in-data replicates the address across the word, so DATA_W is a multiple of ADDR_W.
   function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0] sel,
                                                      input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      case (sel)
         2'd0:    w = {DATA_W{1'b0}};
         2'd1:    w = {DATA_W{1'b1}};
         2'd2:    w = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
         2'd3:    w = {(DATA_W/ADDR_W){a}};
         default: w = {DATA_W{1'b0}};
      endcase
      return w;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic [1:0]          sel_q, sel_d;
   logic [ADDR_W:0]     err_count_q, err_count_d;
   logic [ADDR_W-1:0]   first_err_q, first_err_d;
   logic                timeout_q, timeout_d;
   logic                pass_q, pass_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                w_en_q, w_en_d;
   logic [DATA_W-1:0]   data_in_q, data_in_d;
   logic                log_err;
   logic                advance;

   // Next-state, result bookkeeping and the output values for the state being entered.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wcnt_d      = wcnt_q;
      sel_d       = sel_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      timeout_d   = timeout_q;
      pass_d      = pass_q;
      log_err     = 1'b0;
      advance     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_WRITE;
               addr_d      = ADDR_ZERO;
               sel_d       = pattern_sel;
               err_count_d = ERR_ZERO;
               first_err_d = ADDR_ZERO;
               timeout_d   = 1'b0;
               pass_d      = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_READ_REQ;
               addr_d  = ADDR_ZERO;
            end else begin
               addr_d = addr_q + ADDR_ONE;
            end
         end
         S_READ_REQ: begin
            state_d = S_READ_WAIT;
            wcnt_d  = CNT_ZERO;
         end
         S_READ_WAIT: begin
            // A response arriving in the last wait cycle still wins over the timeout.
            if (Valid_out) begin
               advance = 1'b1;
               if (Data_out != pattern_word(sel_q, addr_q)) begin
                  log_err = 1'b1;
               end else begin
                  log_err = 1'b0;
               end
            end else if (wcnt_q == TMO_LAST) begin
               advance   = 1'b1;
               log_err   = 1'b1;
               timeout_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + CNT_ONE;
            end

            if (log_err) begin
               err_count_d = err_count_q + ERR_ONE;
               if (err_count_q == ERR_ZERO) begin
                  first_err_d = addr_q;
               end else begin
                  first_err_d = first_err_q;
               end
            end else begin
               err_count_d = err_count_q;
            end

            if (advance) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + ADDR_ONE;
                  state_d = S_READ_REQ;
               end
            end else begin
               state_d = S_READ_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      w_en_d = (state_d == S_WRITE);
      busy_d = (state_d == S_WRITE) || (state_d == S_READ_REQ) || (state_d == S_READ_WAIT);
      if (state_d == S_WRITE) begin
         data_in_d = pattern_word(sel_d, addr_d);
      end else begin
         data_in_d = {DATA_W{1'b0}};
      end
      if (state_d == S_DONE) begin
         done_d = 1'b1;
         pass_d = (err_count_d == ERR_ZERO);
      end else begin
         done_d = 1'b0;
      end
   end

   // State and every output flop; reset aborts a test and discards partial results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= ADDR_ZERO;
         wcnt_q      <= CNT_ZERO;
         sel_q       <= 2'd0;
         err_count_q <= ERR_ZERO;
         first_err_q <= ADDR_ZERO;
         timeout_q   <= 1'b0;
         pass_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         w_en_q      <= 1'b0;
         data_in_q   <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wcnt_q      <= wcnt_d;
         sel_q       <= sel_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
         timeout_q   <= timeout_d;
         pass_q      <= pass_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         w_en_q      <= w_en_d;
         data_in_q   <= data_in_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign first_err_addr = first_err_q;
   assign timeout        = timeout_q;
   assign W_en           = w_en_q;
   assign Address        = addr_q;
   assign Data_in        = data_in_q;

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Initiator/sequencer for the 16x32 single-port memory.
- Drives W_en, Address and Data_in; consumes Data_out and Valid_out.
- On start it writes a selectable pattern to every address, reads every address back, compares, and reports pass/fail, error count, first failing address and a timeout flag.
- Sits between the test/CPU control logic and the memory, as its sole master.

Parameters:
ADDR_W, 4, memory address width.
DATA_W, 32, memory data width.
DEPTH, 16, words tested; always equals 2**ADDR_W.
TIMEOUT, 8, READ_WAIT cycles without Valid_out before the read counts as failed; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  begin a test; sampled only in IDLE.
pattern_sel  input  2  0=all-zero, 1=all-ones, 2=checkerboard, 3=address-in-data.
busy  output  1  high from WRITE through READ_WAIT.
done  output  1  one-cycle pulse when the test completes.
pass  output  1  result of the last test; 1 when err_count==0.
err_count  output  ADDR_W+1  number of failing addresses in the last test.
first_err_addr  output  ADDR_W  lowest failing address; 0 if none.
timeout  output  1  at least one read in the last test timed out.
W_en  output  1  memory write enable.
Address  output  ADDR_W  memory address.
Data_in  output  DATA_W  memory write data.
Data_out  input  DATA_W  memory read data.
Valid_out  input  1  memory read data valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - W_en, Address, Data_in, busy, done, pass, err_count, first_err_addr and timeout all go to 0 immediately.
  - All outputs are registered.
- Pattern word for address a:
  - sel0: 0x00000000.
  - sel1: 0xFFFFFFFF.
  - sel2: 0xAAAAAAAA for even a, 0x55555555 for odd a.
  - sel3: a replicated 8 times (e.g. a=5 gives 0x55555555, a=0xC gives 0xCCCCCCCC).
  - pattern_sel is latched at start and held for the whole test.
- State IDLE:
  - W_en=0, busy=0.
  - start=1 clears err_count, first_err_addr and timeout, and sets pass=0.
  - Next state WRITE with addr=0.
- State WRITE:
  - W_en=1, Address=addr, Data_in=pattern(addr), one cycle per address.
  - After addr=DEPTH-1: go to READ_REQ with addr=0.
  - Total: DEPTH cycles.
- State READ_REQ:
  - W_en=0, Address=addr.
  - Lasts one cycle; Valid_out is ignored in this cycle.
  - Next state READ_WAIT with the wait counter at 0.
- State READ_WAIT:
  - W_en=0, Address held.
  - Valid_out=1: compare Data_out with pattern(addr).
    - On mismatch, increment err_count; if this is the first error, latch first_err_addr=addr.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, the address counts as an error (same err/first_err update) and timeout is set to 1.
  - After either outcome: if addr==DEPTH-1 go to DONE, else addr+1 and go to READ_REQ.
  - A compliant memory (Valid_out one cycle after READ_REQ) gives 2 cycles per address.
- State DONE:
  - One cycle: done=1, busy=0, pass=(err_count==0).
  - Next state IDLE.
  - Results hold until the next accepted start.
- Latency with a 1-cycle memory: done is high 16+32+1 = 49 cycles after the start-sampling edge.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - Valid_out during WRITE or IDLE: ignored.
  - err_count maximum is DEPTH (16), which fits in ADDR_W+1 bits; no wrap.
  - Address counter does not wrap past DEPTH-1 within a test.
  - Reset mid-test aborts immediately; no partial results are kept.

Test Plan:
1. Good model memory, pattern_sel=0, start pulse -> 16 write cycles at addresses 0..15 with data 0, then 16 read pairs; done at cycle 49; pass=1, err_count=0, timeout=0.
2. pattern_sel=3, model with bit0 of address 5 stuck at 0 -> read of address 5 returns 0x55555554; err_count=1, first_err_addr=5, pass=0.
3. pattern_sel=2, model corrupting addresses 3 and 9 -> err_count=2, first_err_addr=3, pass=0; also check Data_in alternates 0xAAAAAAAA/0x55555555 during WRITE.
4. Model that never asserts Valid_out -> each read takes 1+TIMEOUT=9 cycles; done at 16+144+1 = 161 cycles; err_count=16, timeout=1, first_err_addr=0.
5. rst low during READ_WAIT at address 7 -> W_en, busy and err_count are 0 immediately; after release, start with pattern_sel=1 completes cleanly with pass=1.
6. start re-pulsed during WRITE and during READ_WAIT -> ignored; the test completes with unchanged timing and results.
